// File: rtl/dmem_pkg.sv
// Shared types, default widths and the address fault check for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Faults on a misaligned byte address or a word index beyond the storage.
  function automatic logic addr_fault(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              stall_o;
  logic              ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  stall_o, ack_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output stall_o, ack_o, rdata_o, err_o
  );

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word storage; no reset, read data holds until the next read.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serialises one access at a time, stalls the pipeline while it is
// outstanding and returns a one-cycle ack after LATENCY cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = DMEM_DATA_W,
  parameter int unsigned ADDR_W  = DMEM_ADDR_W,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q, err_q, rd_valid_q;

  logic              accept, enter_resp;
  logic              acc_we, acc_fault;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              mem_we, mem_re;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.we_i;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wdata_i;
      end
      ack_q <= enter_resp;
      err_q <= enter_resp && acc_fault;
      // rdata_o shows the array output only after a good read; a fault forces it to zero.
      if (enter_resp) begin
        if (acc_fault)    rd_valid_q <= 1'b0;
        else if (!acc_we) rd_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_i) begin
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    accept    = (state_q == StIdle) && bus.req_i;
    // With LATENCY=1 the access happens on the accepting edge, before the latch holds it.
    acc_we    = accept ? bus.we_i    : we_q;
    acc_addr  = accept ? bus.addr_i  : addr_q;
    acc_wdata = accept ? bus.wdata_i : wdata_q;
    acc_fault = addr_fault(64'(acc_addr), DEPTH);
    mem_idx   = acc_addr[IDX_W+1:2];
    mem_we    = enter_resp && acc_we && !acc_fault && !rst_i;
    mem_re    = enter_resp && !acc_we && !acc_fault;

    bus.stall_o = accept || (state_q == StWait);
    bus.ack_o   = ack_q;
    bus.err_o   = err_q;
    bus.rdata_o = rd_valid_q ? mem_rdata : '0;
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (acc_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's data-memory port. It is the other end of the load/store interface driven by the MEM stage.
- Accepts one word-aligned read or write request at a time. Services it after a programmable latency and returns a one-cycle acknowledge with read data.
- Holds `stall_o` high while a request is outstanding, so the CPU can freeze PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Contains the backing word storage.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte address width.
- DEPTH, 256, number of words stored; must be a power of 2.
- LATENCY, 3, cycles from request acceptance to ack; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  request valid from the MEM stage (MemRead | MemWrite).
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- addr_i  in  ADDR_W  byte address; word index = addr_i[log2(DEPTH)+1:2].
- wdata_i  in  DATA_W  write data.
- stall_o  out  1  pipeline freeze request (combinational).
- ack_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_W  read data; valid while ack_o=1 for reads.
- err_o  out  1  access fault; valid while ack_o=1.

Behaviour:
- Reset, asynchronous: state=IDLE, cnt=0, ack_o=0, err_o=0, rdata_o=0, latched request fields cleared. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req_i=1: latch we_i, addr_i, wdata_i.
  - If LATENCY=1, go to RESP.
  - Otherwise load cnt=LATENCY-2 and go to WAIT.
- WAIT:
  - If cnt=0, go to RESP; else cnt <= cnt-1.
  - Inputs are ignored; latched values are used.
- Transition into RESP (edge leaving IDLE or WAIT) performs the access:
  - Read: rdata_o <= mem[idx].
  - Write: mem[idx] <= wdata_latched; rdata_o is unchanged.
  - Fault: addr[1:0]!=0, or addr >> 2 >= DEPTH. No write, rdata_o <= 0, err_o <= 1.
- RESP:
  - ack_o=1 for exactly one cycle; always go to IDLE next.
  - req_i present during RESP is ignored. It is the completing instruction's request, still held.
- Latency: req_i sampled in IDLE at cycle 0; ack_o=1 in cycle LATENCY. No back-to-back acceptance; the next request is accepted no earlier than cycle LATENCY+1.
- stall_o = (state==IDLE & req_i) | (state==WAIT). It is 0 in the ack cycle so the pipeline advances exactly once per completed access.
- ack_o and err_o are registered. err_o returns to 0 when leaving RESP. rdata_o holds its value until the next read or fault completes.
- Reset mid-operation: the outstanding request is abandoned and a pending write is not committed. If reset coincides with the edge entering RESP, reset wins.
- Counter width: 4 bits.
- Same-address write then read returns the new data (no bypass is needed because accesses are serialised).

Decomposition:
- Package `dmem_pkg`:
  - state enum {IDLE, WAIT, RESP}.
  - DATA_W / ADDR_W default constants.
  - Fault-check function (alignment plus range).
- Sub-module `dmem_array`: synchronous single-port word storage.
  - Ports: clk_i, we, idx, wdata, re, rdata.
  - Holds no reset logic.
- The FSM, counter and output registers stay in `dmem_responder`.

Test Plan:
- Reset, then idle for 5 cycles -> ack_o=0, stall_o=0, rdata_o=0, err_o=0 throughout.
- LATENCY=3: write addr 0x10 data 0xDEADBEEF at cycle 0 -> stall_o=1 in cycles 0-2, ack_o=1 only in cycle 3, err_o=0. Then read 0x10 -> rdata_o=0xDEADBEEF with ack in cycle 3 of that request.
- req_i held high continuously (CPU stalled on a load, then a store next) -> second request accepted the cycle after ack. Exactly 2 ack pulses in 8 cycles; the store lands at its own address.
- Misaligned read at 0x13, and out-of-range read at 0x400 (DEPTH=256) -> ack_o=1, err_o=1, rdata_o=0. A later read of 0x10 is unaffected.
- Write 0x20=0x1234 is in WAIT when rst_i pulses asynchronously mid-cycle -> outputs clear immediately, no ack. Reading 0x20 afterwards returns the pre-write content.
- LATENCY=1 sweep: read/write alternating 0x0, 0x4, 0x8 -> ack in the cycle after each request, stall_o high only in the request cycle, data matches a reference model.
